// File: rtl/axi_regbank.sv
// -----------------------------------------------------------------------------
// axi_regbank
//   AXI4-Lite slave exposing NREGS 32-bit registers to software. Writable
//   registers are held here and driven out on slv_reg. Read-only registers
//   return the fabric status word on slv_read. Per-register one-cycle strobes
//   (slv_wr_pulse / slv_rd_pulse) let the fabric react to accesses, for
//   example to implement clear-on-read status.
//
//   Parameters
//     NREGS        number of 32-bit registers (2..256)
//     ADDR_WIDTH   decoded byte-address width (>= clog2(NREGS)+2)
//     RO_MASK      bit i set makes register i read-only
//     RESET_VALUE  per-register reset contents
//
//   Ports
//     clk, reset                 sole rising-edge clock, synchronous active-high reset
//     s_axi_aw*/w*/b*            AXI4-Lite write address, data and response channels
//     s_axi_ar*/r*               AXI4-Lite read address and data channels
//     slv_reg                    current register contents (writable ones change)
//     slv_read                   fabric values returned for read-only registers
//     slv_wr_pulse               one-cycle strobe per register written
//     slv_rd_pulse               one-cycle strobe per register read
//
//   Build option
//     AXI_REGBANK_DECERR_EN      when defined, out-of-range accesses and writes
//                                to read-only registers answer SLVERR (2'b10).
//                                Otherwise every response is OKAY.
// -----------------------------------------------------------------------------
module axi_regbank #(
    parameter int                          NREGS       = 16,
    parameter int                          ADDR_WIDTH  = 8,
    parameter logic [NREGS-1:0]            RO_MASK     = {NREGS{1'b0}},
    parameter logic [NREGS-1:0][31:0]      RESET_VALUE = {NREGS{32'h0000_0000}}
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [31:0]                    s_axi_wdata,
    input  logic [3:0]                     s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [31:0]                    s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NREGS-1:0][31:0]         slv_reg,
    input  logic [NREGS-1:0][31:0]         slv_read,
    output logic [NREGS-1:0]               slv_wr_pulse,
    output logic [NREGS-1:0]               slv_rd_pulse
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WACK  = 3'd1;
    localparam logic [2:0] ST_WRESP = 3'd2;
    localparam logic [2:0] ST_RACK  = 3'd3;
    localparam logic [2:0] ST_RRESP = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]              state_q,    state_d;
    logic                    awready_q,  awready_d;
    logic                    wready_q,   wready_d;
    logic                    bvalid_q,   bvalid_d;
    logic [1:0]              bresp_q,    bresp_d;
    logic                    arready_q,  arready_d;
    logic                    rvalid_q,   rvalid_d;
    logic [31:0]             rdata_q,    rdata_d;
    logic [1:0]              rresp_q,    rresp_d;
    logic [NREGS-1:0][31:0]  slv_reg_q,  slv_reg_d;
    logic [NREGS-1:0]        wr_pulse_q, wr_pulse_d;
    logic [NREGS-1:0]        rd_pulse_q, rd_pulse_d;

    // Word addresses: shifting drops the byte-lane bits [1:0], which are ignored.
    logic [ADDR_WIDTH-1:0]   aw_word_s;
    logic [ADDR_WIDTH-1:0]   ar_word_s;
    logic [NREGS-1:0]        aw_sel_s;
    logic [NREGS-1:0]        ar_sel_s;
    logic [NREGS-1:0]        wr_sel_s;
    logic [31:0]             rd_val_s;
    logic                    aw_err_s;
    logic                    ar_err_s;

    assign aw_word_s = s_axi_awaddr >> 2'd2;
    assign ar_word_s = s_axi_araddr >> 2'd2;

    // One-hot register select; an out-of-range index selects nothing, so
    // such accesses are naturally side-effect-free.
    always_comb begin
        aw_sel_s = {NREGS{1'b0}};
        ar_sel_s = {NREGS{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            aw_sel_s[i] = (32'(aw_word_s) == 32'(i));
            ar_sel_s[i] = (32'(ar_word_s) == 32'(i));
        end
    end

    assign wr_sel_s = aw_sel_s & ~RO_MASK;

`ifdef AXI_REGBANK_DECERR_EN
    // A write errors when it lands on nothing writable; a read only when out of range.
    assign aw_err_s = ~(|wr_sel_s);
    assign ar_err_s = ~(|ar_sel_s);
`else
    assign aw_err_s = 1'b0;
    assign ar_err_s = 1'b0;
`endif

    // Read data mux: fabric status for read-only registers, stored value otherwise.
    always_comb begin
        rd_val_s = 32'h0000_0000;
        for (int i = 0; i < NREGS; i++) begin
            rd_val_s = rd_val_s |
                       ({32{ar_sel_s[i]}} & (RO_MASK[i] ? slv_read[i] : slv_reg_q[i]));
        end
    end

    // Transaction FSM and next-state values of every registered output.
    always_comb begin
        state_d    = state_q;
        awready_d  = 1'b0;
        wready_d   = 1'b0;
        arready_d  = 1'b0;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        slv_reg_d  = slv_reg_q;
        wr_pulse_d = {NREGS{1'b0}};
        rd_pulse_d = {NREGS{1'b0}};
        case (state_q)
            ST_IDLE: begin
                // A complete write request wins over a concurrent read.
                if (s_axi_awvalid && s_axi_wvalid) begin
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    state_d   = ST_WACK;
                end else if (s_axi_arvalid) begin
                    arready_d = 1'b1;
                    state_d   = ST_RACK;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_WACK: begin
                // Handshake completes this cycle, so address/data are still valid.
                for (int i = 0; i < NREGS; i++) begin
                    for (int b = 0; b < 4; b++) begin
                        slv_reg_d[i][b*8 +: 8] = (wr_sel_s[i] && s_axi_wstrb[b]) ?
                                                 s_axi_wdata[b*8 +: 8] :
                                                 slv_reg_q[i][b*8 +: 8];
                    end
                end
                wr_pulse_d = wr_sel_s;
                bvalid_d   = 1'b1;
                bresp_d    = aw_err_s ? RESP_SLVERR : RESP_OKAY;
                state_d    = ST_WRESP;
            end
            ST_WRESP: begin
                if (s_axi_bready) begin
                    bvalid_d = 1'b0;
                    bresp_d  = RESP_OKAY;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_WRESP;
                end
            end
            ST_RACK: begin
                rdata_d    = rd_val_s;
                rresp_d    = ar_err_s ? RESP_SLVERR : RESP_OKAY;
                rvalid_d   = 1'b1;
                rd_pulse_d = ar_sel_s;
                state_d    = ST_RRESP;
            end
            ST_RRESP: begin
                // rdata is deliberately left untouched until the next read.
                if (s_axi_rready) begin
                    rvalid_d = 1'b0;
                    rresp_d  = RESP_OKAY;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_RRESP;
                end
            end
            default: begin
                bvalid_d = 1'b0;
                rvalid_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'h0000_0000;
            rresp_q    <= RESP_OKAY;
            slv_reg_q  <= RESET_VALUE;
            wr_pulse_q <= {NREGS{1'b0}};
            rd_pulse_q <= {NREGS{1'b0}};
        end else begin
            state_q    <= state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            slv_reg_q  <= slv_reg_d;
            wr_pulse_q <= wr_pulse_d;
            rd_pulse_q <= rd_pulse_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign slv_reg       = slv_reg_q;
    assign slv_wr_pulse  = wr_pulse_q;
    assign slv_rd_pulse  = rd_pulse_q;

endmodule

// File: tb/tb_axi_regbank.sv
// -----------------------------------------------------------------------------
// tb_axi_regbank
//   Self-checking bench for axi_regbank (NREGS=16, ADDR_WIDTH=8, registers 1
//   and 5 read-only, distinct reset values). A transaction-level model holds
//   the expected register contents; a negedge compare process checks every
//   DUT output each cycle against it. Directed cases pin the model with
//   literal values, then randomized traffic follows.
// -----------------------------------------------------------------------------
module tb_axi_regbank;

    localparam logic [15:0] RO = 16'h0022;

    function automatic logic [15:0][31:0] mk_rv();
        logic [15:0][31:0] v;
        for (int i = 0; i < 16; i++) v[i] = 32'hC0DE_0000 + 32'(i);
        return v;
    endfunction

    localparam logic [15:0][31:0] RV = mk_rv();

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        s_axi_awaddr;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [7:0]        s_axi_araddr;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic [15:0][31:0] slv_reg;
    logic [15:0][31:0] slv_read;
    logic [15:0]       slv_wr_pulse;
    logic [15:0]       slv_rd_pulse;

    int errors = 0;
    int checks = 0;

    // Model state and the transactions the driver has in flight.
    logic [31:0] mem [16];
    logic [7:0]  pend_waddr;
    logic [31:0] pend_wdata;
    logic [3:0]  pend_wstrb;
    logic [7:0]  pend_raddr;
    int          cyc = 0;
    int          last_bhs_cyc = 0;
    int          last_ar_cyc = 0;

    axi_regbank #(.NREGS(16), .ADDR_WIDTH(8), .RO_MASK(RO), .RESET_VALUE(RV)) dut (
        .clk(clk), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .slv_reg(slv_reg), .slv_read(slv_read),
        .slv_wr_pulse(slv_wr_pulse), .slv_rd_pulse(slv_rd_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_bresp(input logic [7:0] addr);
        int idx = int'(addr >> 2);
`ifdef AXI_REGBANK_DECERR_EN
        return (idx >= 16 || RO[idx & 15]) ? 2'b10 : 2'b00;
`else
        return (idx >= 16) ? 2'b00 : 2'b00;
`endif
    endfunction

    function automatic logic [1:0] exp_rresp(input logic [7:0] addr);
`ifdef AXI_REGBANK_DECERR_EN
        return (int'(addr >> 2) >= 16) ? 2'b10 : 2'b00;
`else
        return (int'(addr >> 2) >= 16) ? 2'b00 : 2'b00;
`endif
    endfunction

    // Per-cycle compare against the model, sampled on the falling edge.
    logic        prev_reset = 1'b1;
    logic        prev_bvalid = 1'b0, prev_bhs = 1'b0;
    logic        prev_rvalid = 1'b0, prev_rhs = 1'b0;
    logic [31:0] prev_rdata = 32'h0;
    always @(negedge clk) begin
        logic [15:0] exp_wp;
        logic [15:0] exp_rp;
        int          idx;
        logic [31:0] exp_rd;
        cyc++;
        exp_wp = 16'h0;
        exp_rp = 16'h0;
        if (prev_reset) begin
            for (int i = 0; i < 16; i++) mem[i] = RV[i];
            check("rst_valid_ready", {27'd0, s_axi_awready, s_axi_wready, s_axi_bvalid,
                                      s_axi_arready, s_axi_rvalid}, 32'd0);
            check("rst_rdata", s_axi_rdata, 32'd0);
            check("rst_resp", {28'd0, s_axi_bresp, s_axi_rresp}, 32'd0);
            check("rst_pulses", {slv_wr_pulse, slv_rd_pulse}, 32'd0);
        end else begin
            if (s_axi_bvalid && !prev_bvalid) begin
                idx = int'(pend_waddr >> 2);
                if (idx < 16 && !RO[idx]) begin
                    for (int b = 0; b < 4; b++)
                        if (pend_wstrb[b]) mem[idx][b*8 +: 8] = pend_wdata[b*8 +: 8];
                    exp_wp[idx] = 1'b1;
                end
                check("bresp", 32'(s_axi_bresp), 32'(exp_bresp(pend_waddr)));
            end else if (prev_bvalid && !prev_bhs) begin
                check("bvalid_hold", 32'(s_axi_bvalid), 32'd1);
            end
            if (s_axi_rvalid && !prev_rvalid) begin
                idx = int'(pend_raddr >> 2);
                exp_rd = 32'h0;
                if (idx < 16) begin
                    exp_rd = RO[idx] ? slv_read[idx] : mem[idx];
                    exp_rp[idx] = 1'b1;
                end
                check("rdata", s_axi_rdata, exp_rd);
                check("rresp", 32'(s_axi_rresp), 32'(exp_rresp(pend_raddr)));
            end else if (prev_rvalid && !prev_rhs) begin
                check("rvalid_hold", 32'(s_axi_rvalid), 32'd1);
                check("rdata_hold", s_axi_rdata, prev_rdata);
            end
            check("wr_pulse", 32'(slv_wr_pulse), 32'(exp_wp));
            check("rd_pulse", 32'(slv_rd_pulse), 32'(exp_rp));
            check("aw_w_ready_pair", 32'(s_axi_awready), 32'(s_axi_wready));
        end
        for (int i = 0; i < 16; i++) check($sformatf("slv_reg[%0d]", i), slv_reg[i], mem[i]);
        if (s_axi_bvalid && s_axi_bready) last_bhs_cyc = cyc;
        if (s_axi_arready) last_ar_cyc = cyc;
        prev_bvalid = s_axi_bvalid;
        prev_bhs    = s_axi_bvalid && s_axi_bready;
        prev_rvalid = s_axi_rvalid;
        prev_rhs    = s_axi_rvalid && s_axi_rready;
        prev_rdata  = s_axi_rdata;
        prev_reset  = reset;
    end

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int bdly, output logic [1:0] resp);
        int n;
        int nb;
        pend_waddr = addr; pend_wdata = data; pend_wstrb = strb;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 8) begin @(posedge clk); #1; n++; end
        check("awready_seen", 32'(s_axi_awready), 32'd1);
        check("aw_latency_le3", 32'(n <= 3), 32'd1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        nb = 0;
        while (!s_axi_bvalid && nb < 8) begin @(posedge clk); #1; nb++; end
        check("bvalid_seen", 32'(s_axi_bvalid), 32'd1);
        check("b_latency_le2", 32'(n + 1 + nb <= 2), 32'd1);
        resp = s_axi_bresp;
        repeat (bdly) begin @(posedge clk); #1; end
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] addr, input int rdly, input bit timed,
                           output logic [31:0] data, output logic [1:0] resp);
        int n;
        int nr;
        pend_raddr = addr;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 40) begin @(posedge clk); #1; n++; end
        check("arready_seen", 32'(s_axi_arready), 32'd1);
        if (timed) check("ar_latency_le3", 32'(n <= 3), 32'd1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        nr = 0;
        while (!s_axi_rvalid && nr < 8) begin @(posedge clk); #1; nr++; end
        check("rvalid_seen", 32'(s_axi_rvalid), 32'd1);
        if (timed) check("r_latency_le2", 32'(n + 1 + nr <= 2), 32'd1);
        data = s_axi_rdata;
        resp = s_axi_rresp;
        repeat (rdly) begin @(posedge clk); #1; end
        s_axi_rready = 1'b1;
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  err_resp;
        int          n;
`ifdef AXI_REGBANK_DECERR_EN
        err_resp = 2'b10;
`else
        err_resp = 2'b00;
`endif
        reset = 1'b1;
        s_axi_awaddr = 8'h0; s_axi_awvalid = 1'b0; s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = 8'h0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0; slv_read = '0;
        pend_waddr = 8'h0; pend_wdata = 32'h0; pend_wstrb = 4'h0; pend_raddr = 8'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("lit_reset_reg3", slv_reg[3], 32'hC0DE_0003);

        // Full-word write, then a single-byte-lane overwrite.
        do_write(8'h0C, 32'hA5A5_1234, 4'hF, 0, resp);
        check("lit_wr_full", slv_reg[3], 32'hA5A5_1234);
        check("lit_wr_full_bresp", 32'(resp), 32'd0);
        do_write(8'h0C, 32'hFFFF_FFFF, 4'b0010, 2, resp);
        check("lit_wr_strb", slv_reg[3], 32'hA5A5_FF34);

        // Read-only register: write ignored, read returns fabric status.
        slv_read[1] = 32'hDEAD_BEEF;
        do_write(8'h04, 32'h0000_0000, 4'hF, 1, resp);
        check("lit_ro_bresp", 32'(resp), 32'(err_resp));
        check("lit_ro_unchanged", slv_reg[1], 32'hC0DE_0001);
        do_read(8'h04, 0, 1'b1, data, resp);
        check("lit_ro_rdata", data, 32'hDEAD_BEEF);

        // Out-of-range read.
        do_read(8'h40, 1, 1'b1, data, resp);
        check("lit_oor_rdata", data, 32'h0);
        check("lit_oor_rresp", 32'(resp), 32'(err_resp));

        // Low address bits are ignored.
        do_write(8'h0F, 32'h1111_2222, 4'hF, 0, resp);
        check("lit_lowbits", slv_reg[3], 32'h1111_2222);

        // Simultaneous write and read: write must finish first.
        fork
            do_write(8'h08, 32'h0BAD_F00D, 4'hF, 3, resp);
            do_read(8'h08, 0, 1'b0, data, resp);
        join
        check("lit_wr_before_rd", 32'(last_ar_cyc > last_bhs_cyc), 32'd1);
        check("lit_rd_after_wr", data, 32'h0BAD_F00D);

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            logic [7:0] a;
            logic [7:0] a2;
            int op;
            for (int i = 0; i < 16; i++) slv_read[i] = $urandom;
            a  = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 63)) : 8'($urandom_range(0, 255));
            a2 = 8'($urandom_range(0, 79));
            op = $urandom_range(0, 2);
            if (op == 0) begin
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), resp);
            end else if (op == 1) begin
                do_read(a, $urandom_range(0, 3), 1'b1, data, resp);
            end else begin
                fork
                    do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), resp);
                    do_read(a2, $urandom_range(0, 3), 1'b0, data, resp);
                join
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        // Long read stall, then reset while the response is pending.
        s_axi_araddr = 8'h0C; pend_raddr = 8'h0C; s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 8) begin @(posedge clk); #1; n++; end
        check("stall_arready", 32'(s_axi_arready), 32'd1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("stall_rvalid", 32'(s_axi_rvalid), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("lit_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("lit_rst_reg3", slv_reg[3], 32'hC0DE_0003);
        repeat (3) begin @(posedge clk); #1; end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
